// File: rtl/strela_cg_ctrl_if.sv
// Handshake bundle between the clock-gate controller (slave) and the gated domain
// plus the clock-gate cell (master).
interface strela_cg_ctrl_if;
  logic busy_i;
  logic sleep_req_i;
  logic wake_req_i;
  logic drain_req_o;
  logic drain_ack_i;
  logic en_o;
  logic gated_o;
  logic wake_ack_o;

  modport slave (
    input  busy_i, sleep_req_i, wake_req_i, drain_ack_i,
    output drain_req_o, en_o, gated_o, wake_ack_o
  );

  modport master (
    output busy_i, sleep_req_i, wake_req_i, drain_ack_i,
    input  drain_req_o, en_o, gated_o, wake_ack_o
  );
endinterface

// File: rtl/strela_cg_ctrl.sv
// Clock-gate controller RUN/DRAIN/GATED/WAKE; registered outputs, one-cycle state response,
// gating waits on drain_ack_i with busy_i low. Auto-idle gating enabled by STRELA_CG_AUTO_IDLE_EN.
module strela_cg_ctrl #(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_en_i,
  strela_cg_ctrl_if.slave       cg
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_GATED = 2'd2;
  localparam logic [1:0] ST_WAKE  = 2'd3;

  localparam logic [7:0] SETTLE_LAST = 8'(WAKE_CYCLES - 1);

  if (IDLE_CYCLES < 1 || IDLE_CYCLES > 65535) begin : g_bad_idle
    $error("IDLE_CYCLES out of range 1..65535");
  end
  if (WAKE_CYCLES < 1 || WAKE_CYCLES > 255) begin : g_bad_wake
    $error("WAKE_CYCLES out of range 1..255");
  end

  logic [1:0] state_q, state_d;
  logic [7:0] settle_q, settle_d;
  logic       en_q, en_d;
  logic       gated_q, gated_d;
  logic       drain_req_q, drain_req_d;
  logic       wake_ack_q, wake_ack_d;
  logic       idle_hit;

`ifdef STRELA_CG_AUTO_IDLE_EN
  localparam int unsigned IW = $clog2(IDLE_CYCLES) + 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);

  logic [IW-1:0] idle_q, idle_d;

  // Counter only lives in RUN; any other state (or an abort back to RUN) restarts it.
  always_comb begin
    idle_d = '0;
    if (!test_en_i && state_q == ST_RUN && !cg.busy_i) begin
      idle_d = (idle_q == '1) ? idle_q : idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) idle_q <= '0;
    else         idle_q <= idle_d;
  end

  assign idle_hit = !cg.busy_i && (idle_q >= IDLE_LAST);
`else
  assign idle_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    settle_d = '0;
    if (test_en_i) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!cg.wake_req_i && (cg.sleep_req_i || idle_hit)) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          // Wake has priority over a simultaneous drain acknowledge.
          if (cg.wake_req_i)                         state_d = ST_RUN;
          else if (cg.drain_ack_i && !cg.busy_i)     state_d = ST_GATED;
        end
        ST_GATED: begin
          if (cg.wake_req_i) state_d = ST_WAKE;
        end
        ST_WAKE: begin
          if (settle_q == SETTLE_LAST) state_d = ST_RUN;
          else                         settle_d = settle_q + 8'd1;
        end
        default: state_d = ST_RUN;
      endcase
    end

    en_d        = (state_d != ST_GATED);
    gated_d     = (state_d == ST_GATED) || (state_d == ST_WAKE);
    drain_req_d = (state_d == ST_DRAIN);
    wake_ack_d  = !test_en_i && (state_q == ST_WAKE) && (state_d == ST_RUN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN;
      settle_q    <= '0;
      en_q        <= 1'b1;
      gated_q     <= 1'b0;
      drain_req_q <= 1'b0;
      wake_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      en_q        <= en_d;
      gated_q     <= gated_d;
      drain_req_q <= drain_req_d;
      wake_ack_q  <= wake_ack_d;
    end
  end

  // Scan mode must see a running clock immediately, without waiting for an edge.
  assign cg.en_o        = en_q | test_en_i;
  assign cg.gated_o     = gated_q;
  assign cg.drain_req_o = drain_req_q;
  assign cg.wake_ack_o  = wake_ack_q;

endmodule

// File: tb/tb_strela_cg_ctrl.sv
// Directed bench for strela_cg_ctrl (IDLE_CYCLES=16, WAKE_CYCLES=2); auto-idle tests follow the macro.
module tb_strela_cg_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic test_en = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  strela_cg_ctrl_if cg_if ();

  strela_cg_ctrl #(.IDLE_CYCLES(16), .WAKE_CYCLES(2)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .test_en_i(test_en),
    .cg       (cg_if)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    test_en = 1'b0;
    cg_if.busy_i = 1'b0;
    cg_if.sleep_req_i = 1'b0;
    cg_if.wake_req_i = 1'b0;
    cg_if.drain_ack_i = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cg_if.busy_i = 1'b0;
    cg_if.sleep_req_i = 1'b0;
    cg_if.wake_req_i = 1'b0;
    cg_if.drain_ack_i = 1'b0;
    step();
    compared++; if (cg_if.en_o !== 1'b1) begin mismatched++; $display("FAIL reset_en: got %b want 1", cg_if.en_o); end
    compared++; if (cg_if.gated_o !== 1'b0) begin mismatched++; $display("FAIL reset_gated: got %b want 0", cg_if.gated_o); end
    compared++; if (cg_if.drain_req_o !== 1'b0) begin mismatched++; $display("FAIL reset_drain: got %b want 0", cg_if.drain_req_o); end
    compared++; if (cg_if.wake_ack_o !== 1'b0) begin mismatched++; $display("FAIL reset_wake_ack: got %b want 0", cg_if.wake_ack_o); end
    rst_n = 1'b1;
  endtask

`ifdef STRELA_CG_AUTO_IDLE_EN
  task automatic test_auto_idle();
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      step();
      compared++; if (cg_if.drain_req_o !== 1'b0) begin mismatched++; $display("FAIL auto_early_drain cycle %0d: got %b want 0", i, cg_if.drain_req_o); end
    end
    step();
    compared++; if (cg_if.drain_req_o !== 1'b1) begin mismatched++; $display("FAIL auto_drain16: got %b want 1", cg_if.drain_req_o); end
    cg_if.drain_ack_i = 1'b1;
    step();
    cg_if.drain_ack_i = 1'b0;
    compared++; if (cg_if.en_o !== 1'b0) begin mismatched++; $display("FAIL auto_gate_en: got %b want 0", cg_if.en_o); end
    compared++; if (cg_if.gated_o !== 1'b1) begin mismatched++; $display("FAIL auto_gate_gated: got %b want 1", cg_if.gated_o); end
  endtask

  task automatic test_busy_restart();
    do_reset();
    for (int i = 0; i < 10; i++) step();
    cg_if.busy_i = 1'b1;
    step();
    cg_if.busy_i = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      compared++; if (cg_if.drain_req_o !== 1'b0) begin mismatched++; $display("FAIL busy_early_drain cycle %0d: got %b want 0", i, cg_if.drain_req_o); end
    end
    step();
    compared++; if (cg_if.drain_req_o !== 1'b1) begin mismatched++; $display("FAIL busy_drain16: got %b want 1", cg_if.drain_req_o); end
  endtask
`else
  task automatic test_no_auto_idle();
    int seen;
    do_reset();
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (cg_if.drain_req_o !== 1'b0) seen++;
    end
    compared++; if (seen !== 0) begin mismatched++; $display("FAIL no_auto_drain: drain seen %0d cycles want 0", seen); end
  endtask
`endif

  task automatic test_sleep_drain();
    do_reset();
    cg_if.sleep_req_i = 1'b1;
    step();
    cg_if.sleep_req_i = 1'b0;
    compared++; if (cg_if.drain_req_o !== 1'b1) begin mismatched++; $display("FAIL sleep_drain: got %b want 1", cg_if.drain_req_o); end
    compared++; if (cg_if.en_o !== 1'b1) begin mismatched++; $display("FAIL sleep_drain_en: got %b want 1", cg_if.en_o); end
    cg_if.drain_ack_i = 1'b1;
    cg_if.busy_i = 1'b1;
    step();
    compared++; if (cg_if.en_o !== 1'b1) begin mismatched++; $display("FAIL busy_blocks_gate: en got %b want 1", cg_if.en_o); end
    compared++; if (cg_if.drain_req_o !== 1'b1) begin mismatched++; $display("FAIL busy_keeps_drain: got %b want 1", cg_if.drain_req_o); end
    cg_if.busy_i = 1'b0;
    step();
    cg_if.drain_ack_i = 1'b0;
    compared++; if (cg_if.en_o !== 1'b0) begin mismatched++; $display("FAIL gated_en: got %b want 0", cg_if.en_o); end
    compared++; if (cg_if.gated_o !== 1'b1) begin mismatched++; $display("FAIL gated_gated: got %b want 1", cg_if.gated_o); end
    compared++; if (cg_if.drain_req_o !== 1'b0) begin mismatched++; $display("FAIL gated_drain: got %b want 0", cg_if.drain_req_o); end
  endtask

  // Continues from GATED; sleep_req held through WAKE must only act once RUN is reached.
  task automatic test_wake();
    cg_if.wake_req_i = 1'b1;
    step();
    cg_if.wake_req_i = 1'b0;
    cg_if.sleep_req_i = 1'b1;
    compared++; if (cg_if.en_o !== 1'b1) begin mismatched++; $display("FAIL wake_en: got %b want 1", cg_if.en_o); end
    compared++; if (cg_if.gated_o !== 1'b1) begin mismatched++; $display("FAIL wake_gated: got %b want 1", cg_if.gated_o); end
    compared++; if (cg_if.wake_ack_o !== 1'b0) begin mismatched++; $display("FAIL wake_ack_early0: got %b want 0", cg_if.wake_ack_o); end
    step();
    compared++; if (cg_if.wake_ack_o !== 1'b0) begin mismatched++; $display("FAIL wake_ack_early1: got %b want 0", cg_if.wake_ack_o); end
    compared++; if (cg_if.drain_req_o !== 1'b0) begin mismatched++; $display("FAIL wake_sleep_ignored: got %b want 0", cg_if.drain_req_o); end
    step();
    compared++; if (cg_if.wake_ack_o !== 1'b1) begin mismatched++; $display("FAIL wake_ack_pulse: got %b want 1", cg_if.wake_ack_o); end
    compared++; if (cg_if.gated_o !== 1'b0) begin mismatched++; $display("FAIL run_gated: got %b want 0", cg_if.gated_o); end
    compared++; if (cg_if.drain_req_o !== 1'b0) begin mismatched++; $display("FAIL run_entry_drain: got %b want 0", cg_if.drain_req_o); end
    step();
    cg_if.sleep_req_i = 1'b0;
    compared++; if (cg_if.wake_ack_o !== 1'b0) begin mismatched++; $display("FAIL wake_ack_single: got %b want 0", cg_if.wake_ack_o); end
    compared++; if (cg_if.drain_req_o !== 1'b1) begin mismatched++; $display("FAIL sleep_after_run: got %b want 1", cg_if.drain_req_o); end
  endtask

  // Continues from DRAIN.
  task automatic test_abort();
    cg_if.wake_req_i = 1'b1;
    cg_if.drain_ack_i = 1'b1;
    step();
    cg_if.drain_ack_i = 1'b0;
    compared++; if (cg_if.drain_req_o !== 1'b0) begin mismatched++; $display("FAIL abort_drain: got %b want 0", cg_if.drain_req_o); end
    compared++; if (cg_if.en_o !== 1'b1) begin mismatched++; $display("FAIL abort_en: got %b want 1", cg_if.en_o); end
    compared++; if (cg_if.gated_o !== 1'b0) begin mismatched++; $display("FAIL abort_gated: got %b want 0", cg_if.gated_o); end
    cg_if.sleep_req_i = 1'b1;
    step();
    cg_if.sleep_req_i = 1'b0;
    compared++; if (cg_if.drain_req_o !== 1'b0) begin mismatched++; $display("FAIL wake_blocks_sleep: got %b want 0", cg_if.drain_req_o); end
    cg_if.wake_req_i = 1'b0;
  endtask

  task automatic go_gated();
    do_reset();
    cg_if.sleep_req_i = 1'b1;
    step();
    cg_if.sleep_req_i = 1'b0;
    cg_if.drain_ack_i = 1'b1;
    step();
    cg_if.drain_ack_i = 1'b0;
  endtask

  task automatic test_test_en();
    go_gated();
    compared++; if (cg_if.en_o !== 1'b0) begin mismatched++; $display("FAIL tst_pre_en: got %b want 0", cg_if.en_o); end
    test_en = 1'b1;
    #1;
    compared++; if (cg_if.en_o !== 1'b1) begin mismatched++; $display("FAIL tst_comb_en: got %b want 1", cg_if.en_o); end
    step();
    compared++; if (cg_if.gated_o !== 1'b0) begin mismatched++; $display("FAIL tst_run_gated: got %b want 0", cg_if.gated_o); end
    compared++; if (cg_if.wake_ack_o !== 1'b0) begin mismatched++; $display("FAIL tst_no_ack: got %b want 0", cg_if.wake_ack_o); end
    test_en = 1'b0;
    step();
    compared++; if (cg_if.en_o !== 1'b1) begin mismatched++; $display("FAIL tst_after_en: got %b want 1", cg_if.en_o); end
    compared++; if (cg_if.wake_ack_o !== 1'b0) begin mismatched++; $display("FAIL tst_after_ack: got %b want 0", cg_if.wake_ack_o); end
  endtask

  task automatic test_reset_in_gated();
    go_gated();
    compared++; if (cg_if.en_o !== 1'b0) begin mismatched++; $display("FAIL rstg_pre_en: got %b want 0", cg_if.en_o); end
    #2;
    rst_n = 1'b0;
    #1;
    compared++; if (cg_if.en_o !== 1'b1) begin mismatched++; $display("FAIL rstg_async_en: got %b want 1", cg_if.en_o); end
    compared++; if (cg_if.gated_o !== 1'b0) begin mismatched++; $display("FAIL rstg_async_gated: got %b want 0", cg_if.gated_o); end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    cg_if.busy_i = 1'b0;
    cg_if.sleep_req_i = 1'b0;
    cg_if.wake_req_i = 1'b0;
    cg_if.drain_ack_i = 1'b0;
    test_reset();
`ifdef STRELA_CG_AUTO_IDLE_EN
    test_auto_idle();
    test_busy_restart();
`else
    test_no_auto_idle();
`endif
    test_sleep_drain();
    test_wake();
    test_abort();
    test_test_en();
    test_reset_in_gated();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
